// File: rtl/aardvark_pkg.sv
// aardvark_pkg: shared constants, next-PC select encoding and clog2 for the Aardvark PC/RAS slice
package aardvark_pkg;
  localparam int ADDR_W_DEFAULT = 8;
  localparam int RESET_PC_DEFAULT = 0;
  typedef enum logic [2:0] {SEL_SEQ, SEL_BR, SEL_CALL, SEL_JR, SEL_RET} pcSelE;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/pc_ras_unit_if.sv
// pc_ras_unit_if: control inputs and PC/return-stack status of the PC unit
interface pc_ras_unit_if #(parameter int ADDR_W = 8, parameter int JIMM_W = 5, parameter int RAS_DEPTH = 4);
  import aardvark_pkg::*;
  logic stall, br_take, call, ret, jr;
  logic [JIMM_W-1:0] jimm;
  logic [ADDR_W-1:0] jr_addr, pc, pc_plus1, ras_top;
  logic [clog2(RAS_DEPTH):0] ras_count;
  logic ras_ovf, ras_unf;
  modport master (output stall, br_take, call, ret, jr, jimm, jr_addr,
                  input pc, pc_plus1, ras_top, ras_count, ras_ovf, ras_unf);
  modport slave (input stall, br_take, call, ret, jr, jimm, jr_addr,
                 output pc, pc_plus1, ras_top, ras_count, ras_ovf, ras_unf);
endinterface

// File: rtl/pc_ras_unit_ras_stack.sv
// ras_stack: circular return-address stack; a push when full overwrites the oldest entry
module ras_stack import aardvark_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int RAS_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic [clog2(RAS_DEPTH):0] count,
  output logic ovf,
  output logic unf
);
  localparam int PTR_W = clog2(RAS_DEPTH);
  localparam logic [PTR_W:0] FULL = (PTR_W + 1)'(RAS_DEPTH);
  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0] ptr, ptrDec;
  assign ptrDec = ptr - 1'b1;
  assign top = (count != '0) ? mem[ptrDec] : '0;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
      count <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      for (int i = 0; i < RAS_DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[ptr] <= push_data;
      ptr <= ptr + 1'b1;
      if (count == FULL) ovf <= 1'b1;
      else count <= count + 1'b1;
    end else if (pop) begin
      if (count != '0) begin
        ptr <= ptrDec;
        count <= count - 1'b1;
      end else unf <= 1'b1;
    end
  end
endmodule

// File: rtl/pc_ras_unit.sv
// pc_ras_unit: program counter with prioritised next-PC select and a hardware return-address stack
module pc_ras_unit import aardvark_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int JIMM_W = 5,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_PC = RESET_PC_DEFAULT
) (
  input logic clk,
  input logic reset,
  pc_ras_unit_if.slave bus
);
  pcSelE sel;
  logic [ADDR_W-1:0] pcQ, pcPlus1, pcRel, immExt, nextPc, rasTop;
  logic [clog2(RAS_DEPTH):0] rasCount;
  logic push, pop, rasEmpty, rasOvf, rasUnf;
  assign sel = bus.ret ? SEL_RET : bus.jr ? SEL_JR : bus.call ? SEL_CALL : bus.br_take ? SEL_BR : SEL_SEQ;
  assign immExt = ADDR_W'(signed'(bus.jimm));
  assign pcPlus1 = pcQ + 1'b1;
  assign pcRel = pcQ + immExt;
  assign rasEmpty = rasCount == '0;
  assign push = !bus.stall && sel == SEL_CALL;
  assign pop = !bus.stall && sel == SEL_RET;
  // an empty-stack return falls back to the architectural $ra value
  assign nextPc = sel == SEL_RET ? (rasEmpty ? bus.jr_addr : rasTop)
                : sel == SEL_JR ? bus.jr_addr
                : (sel == SEL_CALL || sel == SEL_BR) ? pcRel
                : pcPlus1;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pcQ <= ADDR_W'(RESET_PC);
    else if (!bus.stall) pcQ <= nextPc;
  end
  ras_stack #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) uStack (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(pcPlus1),
    .top(rasTop), .count(rasCount), .ovf(rasOvf), .unf(rasUnf)
  );
  assign bus.pc = pcQ;
  assign bus.pc_plus1 = pcPlus1;
  assign bus.ras_top = rasTop;
  assign bus.ras_count = rasCount;
  assign bus.ras_ovf = rasOvf;
  assign bus.ras_unf = rasUnf;
endmodule

// File: tb/tb_pc_ras_unit.sv
// tb_pc_ras_unit: directed self-checking bench for pc_ras_unit with hand-computed expectations
module tb_pc_ras_unit;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int errors = 0;
  pc_ras_unit_if #(.ADDR_W(8), .JIMM_W(5), .RAS_DEPTH(4)) bus ();
  pc_ras_unit #(.ADDR_W(8), .JIMM_W(5), .RAS_DEPTH(4), .RESET_PC(0)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic clr();
    bus.stall = 0; bus.br_take = 0; bus.call = 0; bus.ret = 0; bus.jr = 0;
    bus.jimm = '0; bus.jr_addr = '0;
  endtask
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    clr();
  endtask
  task automatic goto(input logic [7:0] a);
    bus.jr = 1; bus.jr_addr = a;
    step();
  endtask
  initial begin
    clr();
    reset = 0;
    repeat (2) @(negedge clk);
    chk("rst_pc", bus.pc, 0);
    chk("rst_cnt", bus.ras_count, 0);
    chk("rst_ovf", bus.ras_ovf, 0);
    chk("rst_unf", bus.ras_unf, 0);
    chk("rst_top", bus.ras_top, 0);
    reset = 1;
    step(); chk("seq1", bus.pc, 1);
    step(); chk("seq2", bus.pc, 2);
    chk("seq_plus1", bus.pc_plus1, 3);
    step(); chk("seq3", bus.pc, 3);
    reset = 0;
    #1 chk("async_rst", bus.pc, 0);
    @(negedge clk);
    reset = 1;
    step(); chk("seq1b", bus.pc, 1);
    step(); chk("seq2b", bus.pc, 2);
    step(); chk("seq3b", bus.pc, 3);
    step(); chk("seq4b", bus.pc, 4);
    step(); chk("seq5b", bus.pc, 5);
    chk("seq_cnt", bus.ras_count, 0);
    goto(8'h10); chk("jr_10", bus.pc, 8'h10);
    bus.br_take = 1; bus.jimm = 5'b11100;
    step(); chk("br_neg", bus.pc, 8'h0C);
    goto(8'hFE);
    bus.br_take = 1; bus.jimm = 5'd3;
    step(); chk("br_wrap", bus.pc, 8'h01);
    goto(8'h20);
    bus.call = 1; bus.jimm = 5'd8;
    step(); chk("call_pc", bus.pc, 8'h28);
    chk("call_top", bus.ras_top, 8'h21);
    chk("call_cnt", bus.ras_count, 1);
    bus.ret = 1;
    step(); chk("ret_pc", bus.pc, 8'h21);
    chk("ret_cnt", bus.ras_count, 0);
    goto(8'h00);
    for (int i = 0; i < 5; i++) begin
      bus.call = 1; bus.jimm = 5'd4;
      step();
    end
    chk("ovf_pc", bus.pc, 8'h14);
    chk("ovf_flag", bus.ras_ovf, 1);
    chk("ovf_cnt", bus.ras_count, 4);
    chk("ovf_top", bus.ras_top, 8'h11);
    bus.ret = 1; step(); chk("pop1", bus.pc, 8'h11);
    bus.ret = 1; step(); chk("pop2", bus.pc, 8'h0D);
    bus.ret = 1; step(); chk("pop3", bus.pc, 8'h09);
    bus.ret = 1; step(); chk("pop4", bus.pc, 8'h05);
    chk("pop_cnt", bus.ras_count, 0);
    chk("pop_unf", bus.ras_unf, 0);
    chk("ovf_sticky", bus.ras_ovf, 1);
    bus.ret = 1; bus.jr_addr = 8'h3A;
    step(); chk("unf_pc", bus.pc, 8'h3A);
    chk("unf_flag", bus.ras_unf, 1);
    chk("unf_cnt", bus.ras_count, 0);
    goto(8'h3F);
    bus.call = 1; bus.jimm = 5'd5;
    step(); chk("pri_setup_top", bus.ras_top, 8'h40);
    chk("pri_setup_pc", bus.pc, 8'h44);
    bus.ret = 1; bus.call = 1; bus.br_take = 1; bus.jimm = 5'd3;
    step(); chk("pri_ret_pc", bus.pc, 8'h40);
    chk("pri_ret_cnt", bus.ras_count, 0);
    chk("pri_ret_top", bus.ras_top, 0);
    bus.jr = 1; bus.call = 1; bus.jr_addr = 8'h55; bus.jimm = 5'd2;
    step(); chk("pri_jr_pc", bus.pc, 8'h55);
    chk("pri_jr_cnt", bus.ras_count, 0);
    bus.stall = 1; bus.call = 1; bus.jimm = 5'd7;
    step(); chk("stall_pc", bus.pc, 8'h55);
    chk("stall_cnt", bus.ras_count, 0);
    bus.call = 1; bus.jimm = 5'd7;
    step(); chk("post_stall_pc", bus.pc, 8'h5C);
    chk("post_stall_top", bus.ras_top, 8'h56);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
- Parametrised next-generation program-counter unit for the Aardvark core.
- Replaces the discrete pc, add1, addimm and jal/jr muxing with one block.
- Adds a hardware return-address stack (RAS): calls push the return address, returns pop it.
- Sits between the control unit/ALU branch flag and instruction memory address input.

Parameters:
ADDR_W, 8, PC and address width in bits
JIMM_W, 5, width of the signed PC-relative immediate
RAS_DEPTH, 4, number of return-stack entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
stall  in  1  hold PC and stack this cycle
br_take  in  1  taken branch/jump: PC <= PC + sext(jimm)
call  in  1  jal: push PC+1, PC <= PC + sext(jimm)
ret  in  1  jr $ra: pop stack, PC <= popped address
jr  in  1  register jump: PC <= jr_addr, no stack effect
jimm  in  JIMM_W  signed PC-relative immediate
jr_addr  in  ADDR_W  register-file rs value; also return fallback
pc  out  ADDR_W  current PC (registered)
pc_plus1  out  ADDR_W  PC+1 (combinational, for writeback)
ras_top  out  ADDR_W  current top-of-stack value (0 when empty)
ras_count  out  clog2(RAS_DEPTH)+1  valid entries
ras_ovf  out  1  sticky: a push overwrote an entry
ras_unf  out  1  sticky: ret issued with empty stack

Behaviour:
- Reset (reset=0, async) sets pc=RESET_PC, ras_count=0, ras_ovf=0, ras_unf=0, stack pointer=0, all entries=0.
- Reset deassertion is synchronised into the flops by the existing top-level arrangement; the block needs no internal synchroniser.
- All state updates occur on rising clk edges. pc changes one cycle after controls are sampled.
- Arithmetic: sext(jimm) is sign-extended to ADDR_W. All adds are modulo 2^ADDR_W, so the PC wraps silently (0xFF+1 = 0x00 at ADDR_W=8).
- Next-PC priority when several controls are high:
  - ret, then jr, then call, then br_take, then sequential (PC+1).
  - Only the winning control has any stack effect.
- stall=1: pc, stack and flags hold, regardless of the other controls.
- call:
  - Writes PC+1 at the stack pointer, then increments the pointer modulo RAS_DEPTH.
  - If ras_count<RAS_DEPTH, ras_count increments.
  - If the stack is full, the oldest entry is overwritten, ras_count stays at RAS_DEPTH, and ras_ovf is set.
- ret with ras_count>0: decrement the pointer modulo RAS_DEPTH, PC <= that entry, ras_count decrements.
- ret with ras_count=0: PC <= jr_addr (architectural $ra fallback), stack unchanged, ras_unf is set.
- ras_top: entry at pointer-1 when ras_count>0, else 0. Combinational from state.
- Sticky flags clear only on reset.
- Reset mid-call or mid-return: all state returns to reset values immediately; no partial push survives.

Decomposition:
- Shared package aardvark_pkg:
  - ADDR_W default constant.
  - RESET_PC constant.
  - Function clog2.
  - Next-PC select encoding constants (SEL_SEQ, SEL_BR, SEL_CALL, SEL_JR, SEL_RET) used by the priority encoder and the testbench scoreboard.
- One sub-module, ras_stack (circular buffer):
  - Parameters ADDR_W, RAS_DEPTH.
  - Ports clk, reset, push, pop, push_data, top, count, ovf, unf.
- pc_ras_unit contains the priority encoder, the sign extension, the adders and the PC register.

Test Plan:
1. Reset/sequential: reset low then high, 5 cycles, no controls -> pc = 0,1,2,3,4,5; ras_count=0; flags 0. Assert reset at pc=3 -> pc=0 immediately, before the next edge.
2. Branch and wrap: pc=0x10, br_take, jimm=5'b11100 (-4) -> pc=0x0C. pc=0xFE, br_take, jimm=3 -> pc=0x01.
3. Call/return: pc=0x20, call, jimm=8 -> pc=0x28, ras_top=0x21, ras_count=1. Then ret -> pc=0x21, ras_count=0.
4. Overflow (RAS_DEPTH=4): five nested calls from pcs 0x00,0x04,0x08,0x0C,0x10 -> ras_ovf=1, ras_count=4, ras_top=0x11. Four rets -> pc=0x11,0x0D,0x09,0x05.
5. Underflow: empty stack, ret with jr_addr=0x3A -> pc=0x3A, ras_unf=1, ras_count=0.
6. Priority/stall:
   - ret+call+br_take with top=0x40 -> pc=0x40, no push.
   - jr+call with jr_addr=0x55 -> pc=0x55, ras_count unchanged.
   - stall with call -> pc holds, ras_count unchanged.
